// File: rtl/vcm_i2c_pkg.sv
// Shared constants and state encoding for the VCM lens-driver I2C responder.
package vcm_i2c_pkg;

  localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h0C;

  localparam int unsigned VCM_PD_BIT  = 15;
  localparam int unsigned VCM_POS_MSB = 13;
  localparam int unsigned VCM_POS_LSB = 4;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StWaitStop
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the system clock and detects bus clock edges and START/STOP.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl;
  logic                   sda_chg;

  // Idle bus is high on both lines, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl;
      sda_prev_q <= sda;
    end
  end

  assign scl     = scl_sync_q[SYNC_STAGES-1];
  assign sda     = sda_sync_q[SYNC_STAGES-1];
  assign sda_chg = sda ^ sda_prev_q;

  assign start = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop  = scl & scl_prev_q & ~sda_prev_q & sda;

  // An SCL edge coinciding with an SDA change is ambiguous and is dropped.
  assign scl_rise = scl & ~scl_prev_q & ~sda_chg;
  assign scl_fall = ~scl & scl_prev_q & ~sda_chg;

endmodule

// File: rtl/vcm_i2c_responder.sv
// I2C target modelling the VCM lens driver: accepts a 2-byte word, supports read-back.
module vcm_i2c_responder
  import vcm_i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] RESET_WORD  = 16'h0000
) (
  input  logic        CLK_50,
  input  logic        RESET,
  input  logic        I2C_SCL,
  input  logic        I2C_SDA_IN,
  output logic        I2C_SDA_OE,
  output logic [15:0] VCM_DATA,
  output logic [9:0]  VCM_POS,
  output logic        VCM_PD,
  output logic        WR_STROBE,
  output logic        BUSY
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk      (CLK_50),
    .rst      (RESET),
    .scl_in   (I2C_SCL),
    .sda_in   (I2C_SDA_IN),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] data_q, data_d;
  logic        sda_oe_q, sda_oe_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        rw_q, rw_d;
  logic [7:0]  shift_in;

  assign shift_in = {shift_q[6:0], sda};

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      hi_q       <= '0;
      data_q     <= RESET_WORD;
      sda_oe_q   <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      data_q     <= data_d;
      sda_oe_q   <= sda_oe_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    data_d     = data_q;
    sda_oe_d   = sda_oe_q;
    strobe_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;

    if (stop) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d    = StAddr;
      bit_cnt_d  = '0;
      byte_idx_d = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = StAddrAck;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d  = '0;
            byte_idx_d = '0;
            if (rw_q) begin
              state_d  = StRdByte;
              shift_d  = data_q[15:8];
              sda_oe_d = ~data_q[15];
            end else begin
              state_d  = StWrByte;
              sda_oe_d = 1'b0;
            end
          end
        end
        StWrByte: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && byte_idx_q == 2'd0) begin
              hi_d = shift_in;
            end else if (bit_cnt_q == 4'd7 && byte_idx_q == 2'd1) begin
              data_d   = {hi_q, shift_in};
              strobe_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (byte_idx_q == 2'd2) begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
            end else begin
              state_d  = StWrAck;
              sda_oe_d = 1'b1;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            state_d    = StWrByte;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = '0;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        StRdByte: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = StRdAck;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdAck: begin
          // Next byte is preloaded on the master's ACK so the fall only has to drive it.
          if (scl_rise) begin
            if (sda) begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
            end else begin
              shift_d    = byte_idx_q[0] ? data_q[15:8] : data_q[7:0];
              byte_idx_d = {1'b0, ~byte_idx_q[0]};
            end
          end else if (scl_fall) begin
            state_d   = StRdByte;
            bit_cnt_d = '0;
            sda_oe_d  = ~shift_q[7];
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign I2C_SDA_OE = sda_oe_q;
  assign VCM_DATA   = data_q;
  assign VCM_POS    = data_q[VCM_POS_MSB:VCM_POS_LSB];
  assign VCM_PD     = data_q[VCM_PD_BIT];
  assign WR_STROBE  = strobe_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_vcm_i2c_responder.sv
// Bench for vcm_i2c_responder: bit-banged I2C master with ACK/read-byte scoreboards.
module tb_vcm_i2c_responder;

  localparam int unsigned Q = 8;

  logic        CLK_50 = 1'b0;
  logic        RESET;
  logic        scl_m;
  logic        sda_m;
  wire         sda_line;
  logic        I2C_SDA_OE;
  logic [15:0] VCM_DATA;
  logic [9:0]  VCM_POS;
  logic        VCM_PD;
  logic        WR_STROBE;
  logic        BUSY;

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_cnt = 0;
  int oe_seen = 0;
  int busy_seen = 0;

  logic       ack_q[$];
  logic [7:0] rd_q[$];

  assign sda_line = sda_m & ~I2C_SDA_OE;

  vcm_i2c_responder dut (
    .CLK_50     (CLK_50),
    .RESET      (RESET),
    .I2C_SCL    (scl_m),
    .I2C_SDA_IN (sda_line),
    .I2C_SDA_OE (I2C_SDA_OE),
    .VCM_DATA   (VCM_DATA),
    .VCM_POS    (VCM_POS),
    .VCM_PD     (VCM_PD),
    .WR_STROBE  (WR_STROBE),
    .BUSY       (BUSY)
  );

  always #10 CLK_50 = ~CLK_50;

  always @(posedge CLK_50) begin
    if (WR_STROBE === 1'b1) strobe_cnt++;
    if (I2C_SDA_OE === 1'b1) oe_seen++;
    if (BUSY === 1'b1) busy_seen++;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic wait_q();
    repeat (Q) @(negedge CLK_50);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic put_bit(input logic b, output logic seen);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    seen = sda_line;
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(b[i], s);
    put_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic get_byte(input logic m_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, s);
      b[i] = s;
    end
    put_bit(~m_ack, s);
  endtask

  task automatic test_reset();
    RESET = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge CLK_50);
    n_checks++; if (I2C_SDA_OE !== 1'b0) $display("FAIL reset_oe got=%b want=0", I2C_SDA_OE); else n_pass++;
    n_checks++; if (VCM_DATA !== 16'h0000) $display("FAIL reset_data got=%h want=0000", VCM_DATA); else n_pass++;
    n_checks++; if (WR_STROBE !== 1'b0) $display("FAIL reset_strobe got=%b want=0", WR_STROBE); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b want=0", BUSY); else n_pass++;
    RESET = 1'b0;
    repeat (5) @(negedge CLK_50);
  endtask

  task automatic test_write();
    logic [7:0] bytes [3] = '{8'h18, 8'h3F, 8'hF0};
    logic a, e;
    int s0;
    s0 = strobe_cnt;
    for (int i = 0; i < 3; i++) ack_q.push_back(1'b1);
    i2c_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], a);
      e = ack_q.pop_front();
      n_checks++; if (a !== e) $display("FAIL write_ack[%0d] got=%b want=%b", i, a, e); else n_pass++;
      if (i == 0) begin
        n_checks++; if (BUSY !== 1'b1) $display("FAIL write_busy got=%b want=1", BUSY); else n_pass++;
      end
    end
    i2c_stop(); wait_q();
    n_checks++; if (VCM_DATA !== 16'h3FF0) $display("FAIL write_data got=%h want=3ff0", VCM_DATA); else n_pass++;
    n_checks++; if (VCM_POS !== 10'h3FF) $display("FAIL write_pos got=%h want=3ff", VCM_POS); else n_pass++;
    n_checks++; if (VCM_PD !== 1'b0) $display("FAIL write_pd got=%b want=0", VCM_PD); else n_pass++;
    n_checks++; if (strobe_cnt - s0 != 1) $display("FAIL write_strobes got=%0d want=1", strobe_cnt - s0); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL write_busy_end got=%b want=0", BUSY); else n_pass++;
  endtask

  task automatic test_wrong_addr();
    logic [7:0] bytes [3] = '{8'h1A, 8'h12, 8'h34};
    logic a, e;
    oe_seen = 0; busy_seen = 0;
    for (int i = 0; i < 3; i++) ack_q.push_back(1'b0);
    i2c_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], a);
      e = ack_q.pop_front();
      n_checks++; if (a !== e) $display("FAIL wrong_ack[%0d] got=%b want=%b", i, a, e); else n_pass++;
    end
    i2c_stop(); wait_q();
    n_checks++; if (oe_seen != 0) $display("FAIL wrong_oe got=%0d want=0", oe_seen); else n_pass++;
    n_checks++; if (busy_seen != 0) $display("FAIL wrong_busy got=%0d want=0", busy_seen); else n_pass++;
    n_checks++; if (VCM_DATA !== 16'h3FF0) $display("FAIL wrong_data got=%h want=3ff0", VCM_DATA); else n_pass++;
  endtask

  task automatic test_read();
    logic [7:0] wr [3] = '{8'h18, 8'h81, 8'h23};
    logic [7:0] b, eb;
    logic a, e;
    for (int i = 0; i < 4; i++) ack_q.push_back(1'b1);
    i2c_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(wr[i], a);
      e = ack_q.pop_front();
      n_checks++; if (a !== e) $display("FAIL rd_setup_ack[%0d] got=%b want=%b", i, a, e); else n_pass++;
    end
    i2c_stop();
    rd_q.push_back(8'h81); rd_q.push_back(8'h23); rd_q.push_back(8'h81);
    i2c_start();
    send_byte(8'h19, a);
    e = ack_q.pop_front();
    n_checks++; if (a !== e) $display("FAIL rd_addr_ack got=%b want=%b", a, e); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      get_byte(i < 2, b);
      eb = rd_q.pop_front();
      n_checks++; if (b !== eb) $display("FAIL rd_byte[%0d] got=%h want=%h", i, b, eb); else n_pass++;
    end
    oe_seen = 0;
    wait_q();
    n_checks++; if (oe_seen != 0 || I2C_SDA_OE !== 1'b0) $display("FAIL rd_release got=%0d want=0", oe_seen); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rd_busy got=%b want=0", BUSY); else n_pass++;
    i2c_stop(); wait_q();
    n_checks++; if (VCM_DATA !== 16'h8123) $display("FAIL rd_data got=%h want=8123", VCM_DATA); else n_pass++;
  endtask

  task automatic test_partial_and_extra();
    logic [7:0] wr [4] = '{8'h18, 8'h11, 8'h22, 8'h33};
    logic a, e;
    int s0;
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h18, a);
    send_byte(8'h55, a);
    i2c_stop(); wait_q();
    n_checks++; if (strobe_cnt != s0) $display("FAIL partial_strobe got=%0d want=0", strobe_cnt - s0); else n_pass++;
    n_checks++; if (VCM_DATA !== 16'h8123) $display("FAIL partial_data got=%h want=8123", VCM_DATA); else n_pass++;
    ack_q.push_back(1'b1); ack_q.push_back(1'b1); ack_q.push_back(1'b1); ack_q.push_back(1'b0);
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(wr[i], a);
      e = ack_q.pop_front();
      n_checks++; if (a !== e) $display("FAIL extra_ack[%0d] got=%b want=%b", i, a, e); else n_pass++;
    end
    i2c_stop(); wait_q();
    n_checks++; if (VCM_DATA !== 16'h1122) $display("FAIL extra_data got=%h want=1122", VCM_DATA); else n_pass++;
    n_checks++; if (strobe_cnt - s0 != 1) $display("FAIL extra_strobe got=%0d want=1", strobe_cnt - s0); else n_pass++;
  endtask

  task automatic test_rep_start();
    logic a, s;
    int s0;
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h18, a);
    send_byte(8'hAA, a);
    put_bit(1'b1, s); put_bit(1'b0, s); put_bit(1'b1, s);
    i2c_start();
    send_byte(8'h18, a);
    n_checks++; if (a !== 1'b1) $display("FAIL rs_addr_ack got=%b want=1", a); else n_pass++;
    send_byte(8'h00, a);
    send_byte(8'h40, a);
    n_checks++; if (a !== 1'b1) $display("FAIL rs_lo_ack got=%b want=1", a); else n_pass++;
    i2c_stop(); wait_q();
    n_checks++; if (VCM_DATA !== 16'h0040) $display("FAIL rs_data got=%h want=0040", VCM_DATA); else n_pass++;
    n_checks++; if (VCM_POS !== 10'h004) $display("FAIL rs_pos got=%h want=004", VCM_POS); else n_pass++;
    n_checks++; if (strobe_cnt - s0 != 1) $display("FAIL rs_strobe got=%0d want=1", strobe_cnt - s0); else n_pass++;
  endtask

  task automatic test_reset_during_ack();
    logic a, s;
    logic [7:0] addr;
    addr = 8'h18;
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(addr[i], s);
    sda_m = 1'b1; wait_q();
    n_checks++; if (I2C_SDA_OE !== 1'b1) $display("FAIL rst_ack_oe got=%b want=1", I2C_SDA_OE); else n_pass++;
    RESET = 1'b1;
    @(negedge CLK_50);
    n_checks++; if (I2C_SDA_OE !== 1'b0) $display("FAIL rst_ack_release got=%b want=0", I2C_SDA_OE); else n_pass++;
    n_checks++; if (VCM_DATA !== 16'h0000) $display("FAIL rst_ack_data got=%h want=0000", VCM_DATA); else n_pass++;
    RESET = 1'b0;
    wait_q();
    i2c_start();
    send_byte(8'h18, a);
    n_checks++; if (a !== 1'b1) $display("FAIL post_rst_addr_ack got=%b want=1", a); else n_pass++;
    send_byte(8'h92, a);
    send_byte(8'h34, a);
    i2c_stop(); wait_q();
    n_checks++; if (VCM_DATA !== 16'h9234) $display("FAIL post_rst_data got=%h want=9234", VCM_DATA); else n_pass++;
    n_checks++; if (VCM_PD !== 1'b1) $display("FAIL post_rst_pd got=%b want=1", VCM_PD); else n_pass++;
    n_checks++; if (VCM_POS !== 10'h123) $display("FAIL post_rst_pos got=%h want=123", VCM_POS); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_partial_and_extra();
    test_rep_start();
    test_reset_during_ack();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
